// File: rtl/fetch_decode_queue.sv
// Multi-entry fetch-to-decode packet queue with epoch drop and one-cycle flush.
// Optional duplicate-pc filter: define DECQ_DUP_PC_FILTER_EN.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int EPOCH_W = 1,
  parameter int XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [XLEN-1:0]            fetch_inst,
  input  logic [XLEN-1:0]            fetch_pc,
  input  logic [EPOCH_W-1:0]         fetch_epoch,
  input  logic                       pred_taken,
  input  logic [XLEN-1:0]            pred_target,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_inst,
  output logic [XLEN-1:0]            deq_pc,
  output logic                       deq_pred_taken,
  output logic [XLEN-1:0]            deq_pred_target,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0]    inst_q [DEPTH];
  logic [XLEN-1:0]    pc_q   [DEPTH];
  logic [XLEN-1:0]    tgt_q  [DEPTH];
  logic [DEPTH-1:0]   tk_q;

  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [PW-1:0]      head_nxt;
  logic [PW-1:0]      tail_nxt;
  logic [EPOCH_W-1:0] cur_epoch;

  logic has;
  logic deq_fire;
  logic enq_hs;
  logic enq_do;
  logic dup;

`ifdef DECQ_DUP_PC_FILTER_EN
  logic [XLEN-1:0] last_pc;
  logic            last_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc  <= '0;
      last_vld <= 1'b0;
    end else if (redirect_valid) begin
      last_vld <= 1'b0;
    end else if (enq_do) begin
      last_pc  <= fetch_pc;
      last_vld <= 1'b1;
    end
  end

  assign dup = last_vld & (fetch_pc == last_pc);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    has         = (count != '0);
    deq_valid   = has & ~redirect_valid;
    deq_fire    = deq_valid & deq_ready;
    fetch_ready = (count != FULL) | deq_fire;
    enq_hs      = fetch_valid & fetch_ready;
    enq_do      = enq_hs & ~redirect_valid
                & (fetch_epoch == cur_epoch) & ~dup;
    head_nxt    = (head == LAST) ? '0 : head + 1'b1;
    tail_nxt    = (tail == LAST) ? '0 : tail + 1'b1;
  end

  always_comb begin
    deq_inst        = '0;
    deq_pc          = '0;
    deq_pred_taken  = 1'b0;
    deq_pred_target = '0;
    if (has) begin
      deq_inst        = inst_q[head];
      deq_pc          = pc_q[head];
      deq_pred_taken  = tk_q[head];
      deq_pred_target = tgt_q[head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cur_epoch <= '0;
    end else if (redirect_valid) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cur_epoch <= cur_epoch + 1'b1;
    end else begin
      if (enq_do)   tail <= tail_nxt;
      if (deq_fire) head <= head_nxt;
      case ({enq_do, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        tgt_q[i]  <= '0;
      end
      tk_q <= '0;
    end else if (enq_do) begin
      inst_q[tail] <= fetch_inst;
      pc_q[tail]   <= fetch_pc;
      tgt_q[tail]  <= pred_target;
      tk_q[tail]   <= pred_taken;
    end
  end

endmodule
